i2c_reg_sequencer: RTL and testbench
====================================

# i2c_reg_sequencer

Single-requester sequencer that drives the AXI-lite slave port of the `i2c_master_axil` core. It turns simple 8-bit register read/write requests (7-bit device address, 8-bit register index) into the required series of AXI-lite register writes and status polls. It programs the prescale register once after reset, reports NACK or timeout per request, and clears the core's sticky miss_ack flag. It sits between local control logic (sensor/PMIC init FSMs) and `i2c_master_axil`.

## Interface
- PRESCALE, 16'd250: value written to core register 0x0C after reset.
- POLL_LIMIT, 4096: maximum status/data read polls per request before timeout.
- clk  in  1  system clock, shared with `i2c_master_axil`.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_rnw  in  1  1 = read, 0 = write.
- req_dev  in  7  I2C device address.
- req_reg  in  8  register index.
- req_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  8  read data, valid with rsp_valid; 0 for writes and on error.
- rsp_nack  out  1  device failed to ACK (miss_ack seen).
- rsp_timeout  out  1  poll limit exceeded.
- m_axil_*  AXI-lite master: awaddr[3:0], awprot[2:0] (tied 0), awvalid, awready, wdata[31:0], wstrb[3:0] (tied 4'hF), wvalid, wready, bresp[1:0] (ignored), bvalid, bready, araddr[3:0], arprot[2:0] (tied 0), arvalid, arready, rdata[31:0], rresp[1:0] (ignored), rvalid, rready.

## Operation
- Core register map used:
  - 0x00 status: bit0 busy, bit3 miss_ack (write 1 to clear), bit8 cmd_empty, bit11 wr_empty.
  - 0x04 command: [6:0] addr, bit8 start, bit9 read, bit11 write_multiple, bit12 stop.
  - 0x08 data: [7:0] byte, bit8 valid, bit9 last.
  - 0x0C prescale: [15:0].
- AXI write primitive:
  - awvalid and wvalid are asserted together in the same cycle; each drops independently on its own ready.
  - After both handshakes, bready=1 until bvalid.
- AXI read primitive: arvalid until arready, then rready=1 until rvalid; rdata is captured on rvalid.
- States and sequences:
  - INIT: write 0x0C=PRESCALE, then go to IDLE.
  - IDLE: req_ready=1. Accepting a request latches all req_* fields.
  - Write request:
    - W_REG: 0x08 = {valid, reg}.
    - W_DAT: 0x08 = {last, valid, wdata}.
    - W_CMD: 0x04 = {stop, write_multiple, start, dev}.
    - Then POLL_ST.
  - Read request:
    - W_REG: 0x08 = {last, valid, reg}.
    - R_CMD1: 0x04 = {write_multiple, start, dev}.
    - R_CMD2: 0x04 = {stop, read, start, dev}.
    - POLL_RD: read 0x08 until bit8=1, then capture [7:0].
    - Then POLL_ST.
  - POLL_ST: read 0x00 until busy=0 && cmd_empty=1 && wr_empty=1.
    - If miss_ack=1: go to CLR (write 0x00=32'h8), then RESP with nack=1, rdata=0.
    - Otherwise: go to RESP.
  - RESP: pulse rsp_valid for one cycle, then IDLE.
- Poll counter:
  - Cleared on request accept; increments per completed poll read in POLL_RD and POLL_ST.
  - When it reaches POLL_LIMIT without the exit condition: go to CLR, then RESP with timeout=1, rdata=0.
  - If miss_ack is also set in the final status read, nack=1 as well.
  - A NACKed read still ends via POLL_RD; the core delivers the byte with valid set, so the POLL_ST check applies.
- Only one AXI transaction is outstanding at a time; each AXI channel's valid is never deasserted before its ready.

## Timing
- Reset values:
  - All valid outputs and bready/rready = 0; req_ready = 0; rsp_* = 0; awaddr/araddr/wdata = 0.
  - State = INIT. INIT starts in the first cycle after rst_n deasserts.
- Write primitive with zero-wait slave: 2 cycles (aw/w handshake cycle, then bvalid cycle). Read primitive with zero-wait slave: 2 cycles.
- Request accept to first awvalid: 1 cycle.
- rsp_valid rises 1 cycle after the terminating handshake (status rvalid or CLR bvalid). req_ready rises the cycle after rsp_valid.
- awready and wready may arrive in either order or the same cycle. Extra ready-high cycles while the corresponding valid is low are ignored.
- Poll reads are issued back-to-back: a new arvalid goes out the cycle after the previous rvalid.
- Reset mid-transaction: all channels drop immediately and the FSM restarts at INIT. Any half-issued core command is the core's responsibility; the core shares the same reset.

## Test plan
- Reset release with slave model:
  - First transaction is a write of 0x0C = 250.
  - req_ready goes high only after its bvalid.
- Write request dev=0x50, reg=0x10, data=0xA5:
  - AXI writes are 0x08=0x110, 0x08=0x3A5, 0x04=0x1950.
  - Status polls return busy for 5 reads, then 0x900.
  - Expect rsp_valid with nack=0, timeout=0.
- Read request dev=0x68, reg=0x75:
  - AXI writes are 0x08=0x375, 0x04=0x968, 0x04=0x1368.
  - Data polls return 0x000 twice, then 0x171.
  - Expect rsp_rdata=0x71.
- NACK:
  - Status read returns 0x908.
  - Expect a write of 0x00=0x8, then rsp_nack=1, rsp_rdata=0.
- Timeout with POLL_LIMIT=8:
  - Status stuck at 0x001.
  - Expect exactly 8 status reads, a CLR write, then rsp_timeout=1.
- Randomized ready/valid delays (0–7 cycles, aw/w skew) over 200 mixed requests:
  - No valid is dropped before its handshake.
  - Responses match the scoreboard.
  - Assert rst_n low in the middle of W_CMD: all valids drop within the same cycle, then the INIT write occurs again.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Turns 8-bit I2C register read/write requests into i2c_master_axil AXI-lite accesses; one AXI transaction at a time.
// Accept->awvalid 1 cycle; rsp_valid is a one-cycle pulse with no backpressure; req_ready is high only in IDLE.
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'd250,
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rnw,
  input  logic [6:0]  req_dev,
  input  logic [7:0]  req_reg,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_nack,
  output logic        rsp_timeout,
  output logic [3:0]  m_axil_awaddr,
  output logic [2:0]  m_axil_awprot,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic [1:0]  m_axil_bresp,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  output logic [3:0]  m_axil_araddr,
  output logic [2:0]  m_axil_arprot,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready
);

  localparam int CW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    INIT, IDLE, W_REG, W_DAT, W_CMD, R_CMD1, R_CMD2, POLL_RD, POLL_ST, CLR, RESP
  } state_t;

  state_t        state_q, state_d;
  logic          aw_vld_q, aw_vld_d, w_vld_q, w_vld_d, b_rdy_q, b_rdy_d;
  logic          ar_vld_q, ar_vld_d, r_rdy_q, r_rdy_d;
  logic [3:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rnw_q, rnw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d, wdat_q, wdat_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          nack_q, nack_d, tmo_q, tmo_d;
  logic          launch, axi_busy, b_done, r_done, st_exit, st_miss, poll_out;

  assign axi_busy = aw_vld_q | w_vld_q | b_rdy_q | ar_vld_q | r_rdy_q;
  assign b_done   = b_rdy_q & m_axil_bvalid;
  assign r_done   = r_rdy_q & m_axil_rvalid;
  assign cnt_inc  = cnt_q + CW'(1);
  assign poll_out = (cnt_inc == CW'(POLL_LIMIT));
  assign st_exit  = ~m_axil_rdata[0] & m_axil_rdata[8] & m_axil_rdata[11];
  assign st_miss  = m_axil_rdata[3];

  always_comb begin
    state_d  = state_q;
    aw_vld_d = aw_vld_q;
    w_vld_d  = w_vld_q;
    b_rdy_d  = b_rdy_q;
    ar_vld_d = ar_vld_q;
    r_rdy_d  = r_rdy_q;
    awaddr_d = awaddr_q;
    araddr_d = araddr_q;
    wdata_d  = wdata_q;
    rnw_d    = rnw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdat_d   = wdat_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    nack_d   = nack_q;
    tmo_d    = tmo_q;
    launch   = 1'b0;

    if (aw_vld_q && m_axil_awready) aw_vld_d = 1'b0;
    if (w_vld_q && m_axil_wready)   w_vld_d  = 1'b0;
    if ((aw_vld_q || w_vld_q) && !aw_vld_d && !w_vld_d) b_rdy_d = 1'b1;
    if (b_done) b_rdy_d = 1'b0;
    if (ar_vld_q && m_axil_arready) begin
      ar_vld_d = 1'b0;
      r_rdy_d  = 1'b1;
    end
    if (r_done) r_rdy_d = 1'b0;

    // Completion of one step launches the next step's transaction in the same cycle.
    unique case (state_q)
      INIT: begin
        if (b_done) state_d = IDLE;
        else if (!axi_busy) launch = 1'b1;
      end
      IDLE: begin
        if (req_valid) begin
          rnw_d   = req_rnw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdat_d  = req_wdata;
          rdata_d = 8'h00;
          cnt_d   = '0;
          nack_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = W_REG;
          launch  = 1'b1;
        end
      end
      W_REG:  if (b_done) begin state_d = rnw_q ? R_CMD1 : W_DAT; launch = 1'b1; end
      W_DAT:  if (b_done) begin state_d = W_CMD;   launch = 1'b1; end
      W_CMD:  if (b_done) begin state_d = POLL_ST; launch = 1'b1; end
      R_CMD1: if (b_done) begin state_d = R_CMD2;  launch = 1'b1; end
      R_CMD2: if (b_done) begin state_d = POLL_RD; launch = 1'b1; end
      POLL_RD: begin
        if (r_done) begin
          cnt_d  = cnt_inc;
          launch = 1'b1;
          if (m_axil_rdata[8]) begin
            rdata_d = m_axil_rdata[7:0];
            state_d = POLL_ST;
          end else if (poll_out) begin
            tmo_d   = 1'b1;
            state_d = CLR;
          end
        end
      end
      POLL_ST: begin
        if (r_done) begin
          cnt_d = cnt_inc;
          if (st_exit) begin
            if (st_miss) begin
              nack_d  = 1'b1;
              rdata_d = 8'h00;
              state_d = CLR;
              launch  = 1'b1;
            end else begin
              state_d = RESP;
            end
          end else if (poll_out) begin
            tmo_d   = 1'b1;
            nack_d  = st_miss;
            rdata_d = 8'h00;
            state_d = CLR;
            launch  = 1'b1;
          end else begin
            launch = 1'b1;
          end
        end
      end
      CLR:  if (b_done) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase

    if (launch) begin
      unique case (state_d)
        POLL_RD: begin ar_vld_d = 1'b1; araddr_d = 4'h8; end
        POLL_ST: begin ar_vld_d = 1'b1; araddr_d = 4'h0; end
        INIT:    begin aw_vld_d = 1'b1; w_vld_d = 1'b1; awaddr_d = 4'hC; wdata_d = {16'd0, PRESCALE}; end
        W_REG:   begin aw_vld_d = 1'b1; w_vld_d = 1'b1; awaddr_d = 4'h8; wdata_d = {22'd0, rnw_d, 1'b1, reg_d}; end
        W_DAT:   begin aw_vld_d = 1'b1; w_vld_d = 1'b1; awaddr_d = 4'h8; wdata_d = {22'd0, 2'b11, wdat_d}; end
        W_CMD:   begin aw_vld_d = 1'b1; w_vld_d = 1'b1; awaddr_d = 4'h4; wdata_d = 32'h1900 | {25'd0, dev_d}; end
        R_CMD1:  begin aw_vld_d = 1'b1; w_vld_d = 1'b1; awaddr_d = 4'h4; wdata_d = 32'h0900 | {25'd0, dev_d}; end
        R_CMD2:  begin aw_vld_d = 1'b1; w_vld_d = 1'b1; awaddr_d = 4'h4; wdata_d = 32'h1300 | {25'd0, dev_d}; end
        CLR:     begin aw_vld_d = 1'b1; w_vld_d = 1'b1; awaddr_d = 4'h0; wdata_d = 32'h8; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      aw_vld_q <= 1'b0;
      w_vld_q  <= 1'b0;
      b_rdy_q  <= 1'b0;
      ar_vld_q <= 1'b0;
      r_rdy_q  <= 1'b0;
      awaddr_q <= 4'h0;
      araddr_q <= 4'h0;
      wdata_q  <= 32'h0;
      rnw_q    <= 1'b0;
      dev_q    <= 7'h0;
      reg_q    <= 8'h0;
      wdat_q   <= 8'h0;
      rdata_q  <= 8'h0;
      cnt_q    <= '0;
      nack_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aw_vld_q <= aw_vld_d;
      w_vld_q  <= w_vld_d;
      b_rdy_q  <= b_rdy_d;
      ar_vld_q <= ar_vld_d;
      r_rdy_q  <= r_rdy_d;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
      wdata_q  <= wdata_d;
      rnw_q    <= rnw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdat_q   <= wdat_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      nack_q   <= nack_d;
      tmo_q    <= tmo_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = (state_q == RESP) ? rdata_q : 8'h00;
  assign rsp_nack       = (state_q == RESP) & nack_q;
  assign rsp_timeout    = (state_q == RESP) & tmo_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = aw_vld_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = 4'hF;
  assign m_axil_wvalid  = w_vld_q;
  assign m_axil_bready  = b_rdy_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = ar_vld_q;
  assign m_axil_rready  = r_rdy_q;

  logic unused_axil;
  assign unused_axil = ^{m_axil_bresp, m_axil_rresp, m_axil_rdata[31:12], m_axil_rdata[10:9]};

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: random-delay AXI-lite slave scripted per request, scoreboard of expected writes and responses.
module tb_i2c_reg_sequencer;
  localparam int LIM = 8;

  logic clk, rst_n;
  logic req_valid, req_ready, req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic rsp_valid, rsp_nack, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [3:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  i2c_reg_sequencer #(.PRESCALE(16'd250), .POLL_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw), .req_dev(req_dev),
    .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [7:0] rdata; bit nack; bit tmo; int reads; } rsp_t;
  wr_t  exp_wq[$];
  rsp_t exp_rq[$];

  int total = 0, bad = 0, rsp_cnt = 0;
  int s_nd, s_ns;
  bit s_miss, s_stuck, fast;
  logic [7:0] s_byte;
  int dcnt, scnt, rcnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scripted AXI-lite slave: per-channel random readiness, write logging, scripted poll data.
  bit got_aw, got_w, rpend, f_aw, f_w, f_b, f_ar, f_r, p_aw, p_w, p_ar;
  logic [3:0] wa, f_awaddr, f_araddr, p_awaddr, p_araddr;
  logic [31:0] wd, f_wdata, p_wdata, rval;
  initial begin
    wr_t e;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = 0; bresp = 0; rresp = 0;
    got_aw = 0; got_w = 0; rpend = 0; dcnt = 0; scnt = 0; rcnt = 0;
    {f_aw, f_w, f_b, f_ar, f_r, p_aw, p_w, p_ar} = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        got_aw = 0; got_w = 0; rpend = 0;
        {f_aw, f_w, f_b, f_ar, f_r, p_aw, p_w, p_ar} = '0;
      end else begin
        if (f_aw) begin got_aw = 1; wa = f_awaddr; end
        if (f_w)  begin got_w = 1;  wd = f_wdata; end
        if (f_b) begin
          bvalid = 0; got_aw = 0; got_w = 0;
          if (wa == 4'h8) begin dcnt = 0; scnt = 0; rcnt = 0; end
          if (exp_wq.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_extra: got addr %h data %h, want no write", wa, wd);
          end else begin
            e = exp_wq.pop_front();
            check("wr_addr", 64'(wa), 64'(e.a));
            check("wr_data", 64'(wd), 64'(e.d));
          end
        end
        if (f_ar) begin
          rpend = 1; rcnt++;
          if (f_araddr == 4'h8) begin
            rval = (dcnt < s_nd) ? 32'h0 :
                   (32'h100 | 32'(s_byte) | (($urandom_range(0, 1) == 1) ? 32'h200 : 32'h0));
            dcnt++;
          end else begin
            rval = ((scnt < s_ns) || s_stuck) ? (32'h1 | (s_miss ? 32'h8 : 32'h0))
                                              : (32'h900 | (s_miss ? 32'h8 : 32'h0));
            scnt++;
          end
        end
        if (f_r) rvalid = 0;
        if (p_aw) check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
        if (p_w)  check("w_hold",  64'({wvalid, wdata}),   64'({1'b1, p_wdata}));
        if (p_ar) check("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
        awready = fast || ($urandom_range(0, 3) == 0);
        wready  = fast || ($urandom_range(0, 3) == 0);
        arready = fast || ($urandom_range(0, 3) == 0);
        if (got_aw && got_w && !bvalid) bvalid = fast || ($urandom_range(0, 2) == 0);
        if (rpend && !rvalid && (fast || $urandom_range(0, 2) == 0)) begin
          rvalid = 1; rdata = rval; rpend = 0;
        end
        f_aw = awvalid && awready;  f_awaddr = awaddr;
        f_w  = wvalid && wready;    f_wdata  = wdata;
        f_b  = bvalid && bready;
        f_ar = arvalid && arready;  f_araddr = araddr;
        f_r  = rvalid && rready;
        p_aw = awvalid && !awready; p_awaddr = awaddr;
        p_w  = wvalid && !wready;   p_wdata  = wdata;
        p_ar = arvalid && !arready; p_araddr = araddr;
      end
    end
  end

  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        rsp_cnt++;
        if (exp_rq.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_extra: got rdata %h nack %b tmo %b, want no response", rsp_rdata, rsp_nack, rsp_timeout);
        end else begin
          e = exp_rq.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_nack", 64'(rsp_nack), 64'(e.nack));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
          check("poll_reads", 64'(rcnt), 64'(e.reads));
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) begin total++; bad++; $display("FAIL %s: req_ready still low after %0d cycles, want high", nm, n); end
  endtask

  task automatic push_writes(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    if (rnw) begin
      exp_wq.push_back('{a: 4'h8, d: 32'h300 | 32'(rg)});
      exp_wq.push_back('{a: 4'h4, d: 32'h900 | 32'(dev)});
      exp_wq.push_back('{a: 4'h4, d: 32'h1300 | 32'(dev)});
    end else begin
      exp_wq.push_back('{a: 4'h8, d: 32'h100 | 32'(rg)});
      exp_wq.push_back('{a: 4'h8, d: 32'h300 | 32'(wd)});
      exp_wq.push_back('{a: 4'h4, d: 32'h1900 | 32'(dev)});
    end
  endtask

  task automatic drive_req(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    wait_ready("req_wait");
    req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    check("acc_aw", 64'({awvalid, awaddr}), 64'({1'b1, 4'h8}));
  endtask

  task automatic issue(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                       input int nd, input int ns, input bit miss, input bit stuck, input logic [7:0] byt);
    rsp_t r;
    int reads, start, n;
    bit tmo, dtmo, nk;
    s_nd = nd; s_ns = ns; s_miss = miss; s_stuck = stuck; s_byte = byt;
    push_writes(rnw, dev, rg, wd);
    reads = 0; tmo = 0; dtmo = 0;
    if (rnw) begin
      if (nd + 1 > LIM) begin tmo = 1; dtmo = 1; reads = LIM; end
      else reads = nd + 1;
    end
    if (!tmo) begin
      if (stuck || reads + ns + 1 > LIM) begin tmo = 1; reads = LIM; end
      else reads = reads + ns + 1;
    end
    nk = miss && !dtmo;
    if (tmo || nk) exp_wq.push_back('{a: 4'h0, d: 32'h8});
    r.rdata = (rnw && !tmo && !nk) ? byt : 8'h00;
    r.nack = nk; r.tmo = tmo; r.reads = reads;
    exp_rq.push_back(r);
    drive_req(rnw, dev, rg, wd);
    start = rsp_cnt; n = 0;
    while (rsp_cnt == start && n < 3000) begin @(negedge clk); n++; end
    if (rsp_cnt == start) begin total++; bad++; $display("FAIL rsp_wait: no rsp_valid after %0d cycles, want one", n); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 0; fast = 1; req_valid = 0; req_rnw = 0; req_dev = 0; req_reg = 0; req_wdata = 0;
    s_nd = 0; s_ns = 0; s_miss = 0; s_stuck = 0; s_byte = 0;
    #1;
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, req_ready, rsp_valid}), 64'(0));
    check("rst_rsp", 64'({rsp_rdata, rsp_nack, rsp_timeout}), 64'(0));
    check("rst_addr", 64'({awaddr, araddr, wdata}), 64'(0));
    exp_wq.push_back('{a: 4'hC, d: 32'd250});
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("init_aw", 64'({req_ready, awvalid, awaddr}), 64'({1'b0, 1'b1, 4'hC}));
    wait_ready("init_ready");
    check("init_done", 64'(exp_wq.size()), 64'(0));

    issue(0, 7'h50, 8'h10, 8'hA5, 0, 5, 0, 0, 8'h00);
    issue(1, 7'h68, 8'h75, 8'h00, 2, 0, 0, 0, 8'h71);
    issue(0, 7'h21, 8'h03, 8'h5A, 0, 0, 1, 0, 8'h00);
    issue(0, 7'h22, 8'h04, 8'h11, 0, 0, 0, 1, 8'h00);
    issue(1, 7'h23, 8'h05, 8'h00, 1, 0, 1, 0, 8'h99);

    fast = 0;
    for (int i = 0; i < 200; i++)
      issue(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 8'($urandom));

    s_nd = 0; s_ns = 0; s_miss = 0; s_stuck = 0;
    push_writes(0, 7'h3C, 8'h22, 8'h33);
    drive_req(0, 7'h3C, 8'h22, 8'h33);
    n = 0;
    while (!(awvalid && awaddr == 4'h4) && n < 500) begin @(negedge clk); n++; end
    check("wcmd_seen", 64'({awvalid, awaddr}), 64'({1'b1, 4'h4}));
    #2 rst_n = 0;
    #1 check("mid_rst_drop", 64'({awvalid, wvalid, arvalid, bready, rready, req_ready, rsp_valid}), 64'(0));
    exp_wq.delete();
    exp_rq.delete();
    exp_wq.push_back('{a: 4'hC, d: 32'd250});
    repeat (2) @(negedge clk);
    rst_n = 1;
    wait_ready("reinit_ready");
    check("reinit_done", 64'(exp_wq.size()), 64'(0));
    issue(1, 7'h68, 8'h75, 8'h00, 1, 2, 0, 0, 8'hC3);

    repeat (5) @(negedge clk);
    check("drain_wr", 64'(exp_wq.size()), 64'(0));
    check("drain_rsp", 64'(exp_rq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
